// File: rtl/tennis_pkg.sv
// tennis_pkg -- shared types and constants for the tennis ball engine.
//   state_e      : rally FSM states
//   P1 / P2      : player encoding (also the index into the hit vector)
//   MIN_PERIOD   : fastest ball step period in clk cycles
//   RALLY_MAX    : rally counter saturation value
//   sat_inc4     : 4-bit increment that saturates at a limit
package tennis_pkg;

  typedef enum logic [2:0] {
    ST_SERVE = 3'd0,
    ST_TO_P2 = 3'd1,
    ST_TO_P1 = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  localparam int MIN_PERIOD = 2;
  localparam int RALLY_MAX  = 15;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/tennis_ball_engine_btn_edge.sv
// btn_edge -- button synchroniser plus rising-edge detector.
//   gclk   : clock
//   grst_n : async active-low reset
//   btn    : raw asynchronous button (active high)
//   hit    : one-cycle pulse, valid for the 3rd clk edge after btn rises
module btn_edge (
  input  logic gclk,
  input  logic grst_n,
  input  logic btn,
  output logic hit
);

  // [0],[1] are the two synchroniser flops, [2] is the previous synced level.
  logic [2:0] vld_pipe;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) vld_pipe <= '0;
    else         vld_pipe <= {vld_pipe[1:0], btn};
  end

  assign hit = vld_pipe[1] & ~vld_pipe[2];

endmodule

// File: rtl/tennis_ball_engine.sv
// tennis_ball_engine -- two-player LED tennis game.
//   clk             : system clock, rising edge
//   reset_clk       : async active-low reset
//   but_1, but_2    : player buttons (async, active high)
//   led[N_LEDS-1:0] : court; P1 end is led[N_LEDS-1], P2 end is led[0]
//   score_1/score_2 : points won, saturate at WIN_SCORE
//   game_over       : high in the final state; winner 0=P1, 1=P2
// Build option: define SPEEDUP_EN to shorten the step period by one cycle
// per accepted return (floored at MIN_PERIOD, reset each serve).
module tennis_ball_engine
  import tennis_pkg::*;
#(
  parameter int N_LEDS     = 16,
  parameter int TICK_DIV   = 4,
  parameter int HIT_WIN    = 2,
  parameter int WIN_SCORE  = 3,
  parameter int POINT_HOLD = 8
) (
  input  logic              clk,
  input  logic              reset_clk,
  input  logic              but_1,
  input  logic              but_2,
  output logic [N_LEDS-1:0] led,
  output logic [3:0]        score_1,
  output logic [3:0]        score_2,
  output logic              game_over,
  output logic              winner
);

  localparam int PW = $clog2(N_LEDS);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int HW = $clog2(POINT_HOLD + 1);

  localparam logic [PW-1:0] POS_P1    = PW'(N_LEDS - 1);
  localparam logic [PW-1:0] POS_P2    = '0;
  localparam logic [PW-1:0] WIN_LO    = PW'(HIT_WIN);
  localparam logic [PW-1:0] WIN_HI    = PW'(N_LEDS - 1 - HIT_WIN);
  localparam logic [3:0]    WIN_S     = 4'(WIN_SCORE);
  localparam logic [HW-1:0] HOLD_LAST = HW'(POINT_HOLD - 1);
  localparam logic [N_LEDS-1:0] UPPER =
    {{(N_LEDS - N_LEDS/2){1'b1}}, {(N_LEDS/2){1'b0}}};

  // ---- button front end, index = player encoding
  logic [1:0] but;
  logic [1:0] hit;
  assign but = {but_2, but_1};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    btn_edge u_btn (
      .gclk  (clk),
      .grst_n(reset_clk),
      .btn   (but[g]),
      .hit   (hit[g])
    );
  end

  // ---- game state
  state_e          state;
  logic            server;
  logic [PW-1:0]   pos;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   period;
  logic [HW-1:0]   hold;
  logic            step;
  logic            ret_ok;

  // A return is only legal from the receiving player inside their window.
  assign ret_ok = ((state == ST_TO_P2) && hit[P2] && (pos < WIN_LO)) ||
                  ((state == ST_TO_P1) && hit[P1] && (pos > WIN_HI));

  assign step = ((state == ST_TO_P2) || (state == ST_TO_P1)) &&
                (timer >= period - TW'(1));

`ifdef SPEEDUP_EN
  logic [3:0] rally;

  always_ff @(posedge clk or negedge reset_clk) begin
    if (!reset_clk)              rally <= '0;
    else if (state == ST_SERVE)  rally <= '0;
    else if (ret_ok)             rally <= sat_inc4(rally, 4'(RALLY_MAX));
  end

  always_comb begin
    if (TICK_DIV - int'(rally) < MIN_PERIOD) period = TW'(MIN_PERIOD);
    else                                     period = TW'(TICK_DIV - int'(rally));
  end
`else
  assign period = TW'(TICK_DIV);
`endif

  always_ff @(posedge clk or negedge reset_clk) begin
    if (!reset_clk) begin
      state   <= ST_SERVE;
      server  <= P1;
      pos     <= POS_P1;
      timer   <= '0;
      hold    <= '0;
      score_1 <= '0;
      score_2 <= '0;
      winner  <= P1;
    end else begin
      case (state)
        ST_SERVE: begin
          timer <= '0;
          if (hit[server]) state <= (server == P1) ? ST_TO_P2 : ST_TO_P1;
        end

        // The return check comes first so a hit beats a coincident step.
        ST_TO_P2: begin
          if (ret_ok) begin
            state <= ST_TO_P1;
            timer <= '0;
          end else if (step) begin
            timer <= '0;
            if (pos == POS_P2) begin
              score_1 <= sat_inc4(score_1, WIN_S);
              server  <= P2;
              hold    <= '0;
              state   <= ST_POINT;
            end else begin
              pos <= pos - PW'(1);
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        ST_TO_P1: begin
          if (ret_ok) begin
            state <= ST_TO_P2;
            timer <= '0;
          end else if (step) begin
            timer <= '0;
            if (pos == POS_P1) begin
              score_2 <= sat_inc4(score_2, WIN_S);
              server  <= P1;
              hold    <= '0;
              state   <= ST_POINT;
            end else begin
              pos <= pos + PW'(1);
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        // server already holds the player who lost the point.
        ST_POINT: begin
          if (hold == HOLD_LAST) begin
            if ((score_1 == WIN_S) || (score_2 == WIN_S)) begin
              state  <= ST_OVER;
              winner <= (score_2 == WIN_S);
            end else begin
              state <= ST_SERVE;
              pos   <= (server == P1) ? POS_P1 : POS_P2;
            end
          end else begin
            hold <= hold + HW'(1);
          end
        end

        ST_OVER: ;

        default: state <= ST_SERVE;
      endcase
    end
  end

  always_comb begin
    led = '0;
    case (state)
      ST_POINT: led = '1;
      ST_OVER:  led = (winner == P1) ? UPPER : ~UPPER;
      default:  led[pos] = 1'b1;
    endcase
  end

  assign game_over = (state == ST_OVER);

endmodule

// File: doc/tennis_ball_engine.md
TENNIS_BALL_ENGINE -- requirements
Module: tennis_ball_engine

Interface
REQ-001 SHALL have parameter N_LEDS, default 16, court length in LED positions (min 4).
REQ-002 SHALL have parameter TICK_DIV, default 4, clk cycles per ball step at rally start (min 2).
REQ-003 SHALL have parameter HIT_WIN, default 2, positions at each end where a return is accepted.
REQ-004 SHALL have parameter WIN_SCORE, default 3, points needed to win.
REQ-005 SHALL have parameter POINT_HOLD, default 8, cycles the point display is held.
REQ-006 clk  in  1  single system clock, all logic on rising edge.
REQ-007 reset_clk  in  1  asynchronous, active-low reset.
REQ-008 but_1  in  1  player 1 button, asynchronous, active-high.
REQ-009 but_2  in  1  player 2 button, asynchronous, active-high.
REQ-010 led  out  N_LEDS  court display; P1 end is led[N_LEDS-1], P2 end is led[0].
REQ-011 score_1, score_2  out  4 each  points won per player.
REQ-012 game_over  out  1  high once either score reaches WIN_SCORE; winner  out  1  0=P1, 1=P2.

Function
REQ-013 Each button SHALL pass a 2-FF synchroniser and rising-edge detector; a single-cycle hit pulse reaches the FSM on the 3rd clk edge after the input rises.
REQ-014 FSM states SHALL be SERVE, TO_P2, TO_P1, POINT, OVER.
REQ-015 SERVE: ball held at the server's end (pos N_LEDS-1 for P1, 0 for P2); server's hit pulse -> TO_P2 (P1 serving) or TO_P1 (P2 serving); other button ignored.
REQ-016 Step timer SHALL count 0..period-1; at wrap pos moves one place (TO_P2 decrement, TO_P1 increment); timer clears on every direction change.
REQ-017 In TO_P2, a P2 hit pulse while pos < HIT_WIN SHALL switch to TO_P1 and increment rally count; P2 pulses outside the window and all P1 pulses SHALL be ignored; TO_P1 mirrors with pos > N_LEDS-1-HIT_WIN.
REQ-018 Hit pulse and step in the same cycle: the hit SHALL win; pos unchanged that cycle.
REQ-019 Step from pos 0 in TO_P2 (or N_LEDS-1 in TO_P1) SHALL be a miss: opponent's score +1, enter POINT; pos never wraps.
REQ-020 POINT: led all ones for POINT_HOLD cycles, then OVER if a score equals WIN_SCORE, else SERVE with the player who lost the point serving.
REQ-021 OVER: led lights the winner's half (P1 upper, P2 lower), game_over=1, held until reset; buttons ignored.
REQ-022 Outside POINT/OVER, led SHALL be one-hot at pos.
REQ-023 Scores SHALL saturate at WIN_SCORE; rally count SHALL saturate at 15.

Reset
REQ-024 Reset SHALL force SERVE, P1 serving, pos=N_LEDS-1, led=one-hot at N_LEDS-1, scores 0, game_over=0, winner=0, timer 0, synchroniser flops 0; mid-rally reset SHALL discard the rally with no score change.

Configuration
REQ-025 With SPEEDUP_EN defined, step period SHALL be TICK_DIV minus rally count, floored at 2, rally count cleared on entering SERVE.
REQ-026 Without SPEEDUP_EN, step period SHALL be constant TICK_DIV and rally count logic SHALL be absent.

Structure
REQ-027 Package tennis_pkg SHALL hold the FSM state enum, player encoding (P1=0, P2=1) and MIN_PERIOD=2.
REQ-028 Sub-module btn_edge (synchroniser plus rising-edge detector) SHALL be instantiated once per button.

Verification (defaults; WIN_SCORE=3)
REQ-029 Reset low then high -> led=16'h8000, scores 0, state SERVE; no motion without but_1.
REQ-030 but_1 pulse, no returns -> ball reaches led=16'h0001 then miss; score_1=1, led=16'hFFFF for 8 cycles, then led=16'h0001 serving P2.
REQ-031 but_2 rising when led=16'h0002 (pos 1) -> direction reverses, next step shows led=16'h0004; but_2 at pos 5 -> ignored, ball continues.
REQ-032 Hit pulse coincident with step at pos 0 -> return accepted, no miss, pos stays 0 then goes to 1.
REQ-033 SPEEDUP_EN with 3 returns -> step interval 4,3,2,2 cycles; without macro stays 4.
REQ-034 P1 wins three points -> game_over=1, winner=0, led=16'hFF00 held; reset_clk low mid-rally -> REQ-024 state immediately, no clock needed.
